// File: rtl/pacman_collision_if.sv
// Signal bundle between the sprite movers/renderer and the collision controller.
// The controller takes the slave side: it reads positions and frame strobes, and drives game state.
interface pacman_collision_if #(
   parameter int NUM_GHOSTS = 4
);
   logic                    frame_stb;
   logic [8:0]              x_pac;
   logic [8:0]              y_pac;
   logic [9*NUM_GHOSTS-1:0] x_ghost;
   logic [9*NUM_GHOSTS-1:0] y_ghost;
   logic                    freeze;
   logic                    movers_rst;
   logic                    death_pulse;
   logic [2:0]              hit_id;
   logic [1:0]              lives;
   logic                    game_over;

   modport master (
      output frame_stb, x_pac, y_pac, x_ghost, y_ghost,
      input  freeze, movers_rst, death_pulse, hit_id, lives, game_over
   );

   modport slave (
      input  frame_stb, x_pac, y_pac, x_ghost, y_ghost,
      output freeze, movers_rst, death_pulse, hit_id, lives, game_over
   );
endinterface

// File: rtl/pacman_collision_ctrl.sv
// Pac-Man vs ghost collision controller: on a frame strobe it detects a hit, takes a life,
// freezes play for DEATH_FRAMES strobes, then issues a one-cycle respawn or latches game-over.
module pacman_collision_ctrl #(
   parameter int NUM_GHOSTS   = 4,
   parameter int HIT_DIST     = 6,
   parameter int DEATH_FRAMES = 120,
   parameter int START_LIVES  = 3
) (
   input logic               vga_pix_clk,
   input logic               rst,
   pacman_collision_if.slave bus
);
   localparam int               CNT_W         = $clog2(DEATH_FRAMES + 1);
   localparam logic [9:0]       HIT_DIST_L    = 10'(HIT_DIST);
   localparam logic [CNT_W-1:0] LAST_CNT      = CNT_W'(DEATH_FRAMES - 1);
   localparam logic [1:0]       START_LIVES_L = 2'(START_LIVES);

   typedef enum logic [1:0] {
      PLAYING,
      DYING,
      RESPAWN,
      GAME_OVER
   } state_e;

   // A 10-bit signed difference keeps far-apart sprites far apart (no 9-bit wrap).
   function automatic logic [9:0] abs_diff(input logic [8:0] a, input logic [8:0] b);
      logic signed [9:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      return d[9] ? $unsigned(-d) : $unsigned(d);
   endfunction

   state_e           state_q, state_d;
   logic [1:0]       lives_q, lives_d;
   logic [2:0]       hit_id_q, hit_id_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             death_pulse_q, death_pulse_d;

   logic             any_hit;
   logic [2:0]       hit_idx;

   // Scan downward so the lowest colliding ghost wins.
   always_comb begin
      any_hit = 1'b0;
      hit_idx = '0;
      for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
         if ((abs_diff(bus.x_pac, bus.x_ghost[9*i +: 9]) < HIT_DIST_L) &&
             (abs_diff(bus.y_pac, bus.y_ghost[9*i +: 9]) < HIT_DIST_L)) begin
            any_hit = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         state_q       <= PLAYING;
         lives_q       <= START_LIVES_L;
         hit_id_q      <= '0;
         cnt_q         <= '0;
         death_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lives_q       <= lives_d;
         hit_id_q      <= hit_id_d;
         cnt_q         <= cnt_d;
         death_pulse_q <= death_pulse_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      lives_d       = lives_q;
      hit_id_d      = hit_id_q;
      cnt_d         = cnt_q;
      death_pulse_d = 1'b0;
      unique case (state_q)
         PLAYING: begin
            if (bus.frame_stb && any_hit) begin
               state_d       = DYING;
               hit_id_d      = hit_idx;
               lives_d       = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
               cnt_d         = '0;
               death_pulse_d = 1'b1;
            end
         end
         DYING: begin
            if (bus.frame_stb) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) begin
                  state_d = (lives_q == 2'd0) ? GAME_OVER : RESPAWN;
               end
            end
         end
         RESPAWN:   state_d = PLAYING;
         GAME_OVER: state_d = GAME_OVER;
         default:   state_d = PLAYING;
      endcase
   end

   // Outputs decode registered state only; nothing is combinational from the inputs.
   assign bus.freeze      = (state_q != PLAYING);
   assign bus.movers_rst  = (state_q == RESPAWN);
   assign bus.game_over   = (state_q == GAME_OVER);
   assign bus.death_pulse = death_pulse_q;
   assign bus.hit_id      = hit_id_q;
   assign bus.lives       = lives_q;
endmodule
